// File: rtl/div16x8_seq.sv
// Sequential restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// Uses a start/done handshake; a zero divisor completes immediately with a saturated quotient.
module div16x8_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] work;
    logic [7:0]  dvsr;
    logic [7:0]  rem;
    logic [3:0]  cnt;

    logic        accept;
    logic [8:0]  t;
    logic        ge;
    logic [7:0]  rem_sub;
    logic [15:0] work_nxt;
    logic [7:0]  rem_nxt;

    assign accept = start && (state == IDLE || state == DONE);

    // The 9th bit of t only feeds the compare; once subtracted the
    // remainder is below the divisor, so the low 8 bits of the difference are exact.
    always_comb begin
        t        = {rem, work[15]};
        ge       = (t >= {1'b0, dvsr});
        rem_sub  = t[7:0] - dvsr;
        work_nxt = {work[14:0], ge};
        rem_nxt  = ge ? rem_sub : t[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start)             state_nxt = (divisor == 8'd0) ? DONE : CALC;
                else if (state == DONE) state_nxt = IDLE;
            end
            CALC:    if (cnt == 4'd15) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work        <= '0;
            dvsr        <= '0;
            rem         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (divisor == 8'd0) begin
                quotient    <= 16'hFFFF;
                remainder   <= dividend[7:0];
                div_by_zero <= 1'b1;
            end else begin
                work        <= dividend;
                dvsr        <= divisor;
                rem         <= '0;
                cnt         <= '0;
                div_by_zero <= 1'b0;
            end
        end else if (state == CALC) begin
            work <= work_nxt;
            rem  <= rem_nxt;
            cnt  <= cnt + 4'd1;
            if (cnt == 4'd15) begin
                quotient  <= work_nxt;
                remainder <= rem_nxt;
            end
        end
    end

endmodule

// File: tb/tb_div16x8_seq.sv
// Directed and randomized self-checking bench for div16x8_seq.
// Inputs are driven and outputs sampled on the falling edge.
module tb_div16x8_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    div16x8_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Pulse start for one cycle, scramble operands afterwards, wait for done (bounded).
    task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input int exp_lat, input logic [15:0] eq, input logic [7:0] er,
                          input logic ed);
        int n;
        int bc;
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; dividend = ~a; divisor = b + 8'd1;
        n = 1; bc = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            n++;
        end
        check({tag, ".latency"}, n, exp_lat);
        check({tag, ".busy_cycles"}, bc, (exp_lat == 17) ? 16 : 0);
        check({tag, ".quotient"}, quotient, eq);
        check({tag, ".remainder"}, remainder, er);
        check({tag, ".div_by_zero"}, div_by_zero, ed);
        @(negedge clk);
        check({tag, ".done_one_cycle"}, done, 1'b0);
    endtask

    initial begin
        int pulses;
        int first_done;
        int second_done;
        logic [15:0] a;
        logic [7:0]  b;

        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);
        check("reset.quotient", quotient, 16'd0);
        check("reset.remainder", remainder, 8'd0);
        check("reset.div_by_zero", div_by_zero, 1'b0);
        reset = 1'b0;

        run_op("1000/7", 16'd1000, 8'd7, 17, 16'd142, 8'd6, 1'b0);
        run_op("FFFF/1", 16'hFFFF, 8'd1, 17, 16'hFFFF, 8'd0, 1'b0);
        run_op("FFFF/255", 16'hFFFF, 8'd255, 17, 16'd257, 8'd0, 1'b0);
        run_op("200/255", 16'd200, 8'd255, 17, 16'd0, 8'd200, 1'b0);
        run_op("0/5", 16'd0, 8'd5, 17, 16'd0, 8'd0, 1'b0);
        run_op("1234/0", 16'h1234, 8'd0, 1, 16'hFFFF, 8'h34, 1'b1);
        run_op("9/3", 16'd9, 8'd3, 17, 16'd3, 8'd0, 1'b0);

        // Start during CALC must be ignored.
        @(negedge clk);
        dividend = 16'd100; divisor = 8'd9; start = 1'b1;
        pulses = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                check("ignore.quotient", quotient, 16'd11);
                check("ignore.remainder", remainder, 8'd1);
            end
            start = 1'b0;
            if (n == 5) begin
                dividend = 16'd50; divisor = 8'd5; start = 1'b1;
            end
        end
        check("ignore.done_pulses", pulses, 1);

        // Start held high: back-to-back operations.
        @(negedge clk);
        dividend = 16'd500; divisor = 8'd3; start = 1'b1;
        first_done = 0; second_done = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                dividend = 16'd77; divisor = 8'd8;
            end
            if (n == 18) start = 1'b0;
            if (done === 1'b1) begin
                if (first_done == 0) begin
                    first_done = n;
                    check("b2b.first_quotient", quotient, 16'd166);
                    check("b2b.first_remainder", remainder, 8'd2);
                end else if (second_done == 0) begin
                    second_done = n;
                    check("b2b.second_quotient", quotient, 16'd9);
                    check("b2b.second_remainder", remainder, 8'd5);
                end
            end
        end
        check("b2b.first_latency", first_done, 17);
        check("b2b.spacing", second_done - first_done, 17);
        start = 1'b0;

        // Reset mid-CALC abandons the operation.
        @(negedge clk);
        dividend = 16'd60000; divisor = 8'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid.busy", busy, 1'b0);
        check("rst_mid.done", done, 1'b0);
        check("rst_mid.quotient", quotient, 16'd0);
        check("rst_mid.remainder", remainder, 8'd0);
        pulses = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("rst_mid.no_done", pulses, 0);
        run_op("60000/13", 16'd60000, 8'd13, 17, 16'd4615, 8'd5, 1'b0);

        for (int i = 0; i < 500; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = 8'($urandom_range(1, 255));
            run_op("rand", a, b, 17, a / {8'd0, b}, 8'(a % {8'd0, b}), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
